// File: rtl/spi_master.sv
// spi_master -- CPU-bus SPI master peripheral (mode 0, MSB first).
//
// Sits on the 6502 data bus next to the ACIA. Software writes a byte to DATA
// to launch an 8-bit exchange; the received byte is read back from DATA once
// STATUS.done is set. A level interrupt (done & irq_en) is available.
//
// Registers (rs):
//   0 DATA   W: start transfer (ignored while busy)   R: last received byte
//   1 STATUS R: {busy, done, 6'b0}                     W: ignored
//   2 CTRL   R/W: bit0 ss (spi_cs_n = ~ss), bit1 irq_en
//   3 DIV    R/W: SCK half-period = DIV+1 clk cycles (writes ignored while busy)
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cs, we, rs, din CPU bus select / write enable / register select / data
//   dout            registered read data (valid the cycle after the address)
//   irq             interrupt request, active high, registered
//   spi_sck         serial clock, idles low
//   spi_mosi        serial data out
//   spi_miso        serial data in
//   spi_cs_n        slave select, active low
module spi_master #(
   parameter logic [7:0] DIV_RESET = 8'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] rs,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic       ss;
   logic       irq_en;
   logic [7:0] div;
   logic [7:0] rx;
   logic [7:0] shift;
   logic       done;
   logic [7:0] half_cnt;
   logic [4:0] edge_cnt;

   logic       busy;
   logic       data_wr;
   logic       data_rd;
   logic       ctrl_wr;
   logic       div_wr;
   logic       half_wrap;
   logic [4:0] edge_nxt;
   logic       last_edge;

   // Bus decode and SCK edge timing
   always_comb begin
      busy      = (state == SHIFT);
      data_wr   = cs & we & (rs == 2'd0);
      data_rd   = cs & ~we & (rs == 2'd0);
      ctrl_wr   = cs & we & (rs == 2'd2);
      div_wr    = cs & we & (rs == 2'd3);
      // div is frozen while busy, so an equality compare is safe here
      half_wrap = busy & (half_cnt == div);
      edge_nxt  = edge_cnt + 5'd1;
      last_edge = half_wrap & (edge_nxt == 5'd16);
   end

   assign spi_cs_n = ~ss;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_wr)   state_nxt = SHIFT;
         SHIFT:   if (last_edge) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registers, shifter and read mux
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss       <= 1'b0;
         irq_en   <= 1'b0;
         div      <= DIV_RESET;
         rx       <= 8'h00;
         shift    <= 8'h00;
         done     <= 1'b0;
         half_cnt <= 8'h00;
         edge_cnt <= 5'd0;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
         irq      <= 1'b0;
         dout     <= 8'h00;
      end else begin
         // CTRL takes effect at once, even mid-transfer; dropping ss does
         // not abort the shift in progress.
         if (ctrl_wr) begin
            ss     <= din[0];
            irq_en <= din[1];
         end

         if (div_wr && !busy) begin
            div <= din;
         end

         if (!busy) begin
            if (data_wr) begin
               shift    <= din;
               spi_mosi <= din[7];
               half_cnt <= 8'h00;
               edge_cnt <= 5'd0;
            end
         end else if (half_wrap) begin
            half_cnt <= 8'h00;
            edge_cnt <= edge_nxt;
            if (edge_nxt[0]) begin
               // rising SCK: sample MISO
               spi_sck <= 1'b1;
               shift   <= {shift[6:0], spi_miso};
            end else begin
               // falling SCK: present next bit, except after the final edge
               // where MOSI simply holds
               spi_sck <= 1'b0;
               if (edge_nxt != 5'd16) begin
                  spi_mosi <= shift[7];
               end
            end
         end else begin
            half_cnt <= half_cnt + 8'd1;
         end

         // completion beats a same-cycle DATA read
         if (last_edge) begin
            rx   <= shift;
            done <= 1'b1;
         end else if (data_rd) begin
            done <= 1'b0;
         end

         irq <= done & irq_en;

         // read mux is registered every cycle regardless of cs
         case (rs)
            2'd0: dout <= rx;
            2'd1: dout <= {busy, done, 6'b000000};
            2'd2: dout <= {6'b000000, irq_en, ss};
            2'd3: dout <= div;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master: reset, loopback, slave model, interrupt,
// ignored writes and mid-transfer reset abort.
module tb_spi_master;

   logic       clk;
   logic       rst;
   logic       cs;
   logic       we;
   logic [1:0] rs;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_cs_n;

   int n_assert = 0;
   int n_fail   = 0;

   // external SPI environment
   logic        loop_mode  = 1'b1;
   logic [7:0]  slave_byte = 8'h00;
   int          fall_base  = 0;
   int          fall_cnt   = 0;
   int          sck_rises  = 0;
   int          irq_cycles = 0;
   logic [31:0] mosi_hist  = 32'h0;

   spi_master #(.DIV_RESET(8'd3)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .we       (we),
      .rs       (rs),
      .din      (din),
      .dout     (dout),
      .irq      (irq),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_cs_n (spi_cs_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // MISO: either loopback of MOSI or a mode-0 slave shifting out slave_byte
   always_comb begin
      int idx;
      idx      = fall_cnt - fall_base;
      spi_miso = 1'b0;
      if (loop_mode)
         spi_miso = spi_mosi;
      else if (idx >= 0 && idx < 8)
         spi_miso = slave_byte[7-idx];
   end

   always @(negedge spi_sck) fall_cnt <= fall_cnt + 1;

   always @(posedge spi_sck) begin
      sck_rises <= sck_rises + 1;
      mosi_hist <= {mosi_hist[30:0], spi_mosi};
   end

   always @(posedge clk) if (irq === 1'b1) irq_cycles <= irq_cycles + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   // bus tasks are entered and left at a negedge
   task automatic bus_write(input logic [1:0] r, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; rs = r; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] r, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; rs = r;
      @(negedge clk);
      d  = dout;
      cs = 1'b0;
   endtask

   // counts STATUS samples with busy=1; starting right after the start write
   // the count equals the number of busy cycles
   task automatic poll_busy(output int n);
      cs = 1'b1; we = 1'b0; rs = 2'd1; n = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (dout[7] === 1'b1) n++;
         else break;
      end
      cs = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      int         n;
      int         rbase;
      int         ibase;
      int         irq_early;

      rst = 1'b0; cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00;

      // ---- reset, asserted mid-cycle
      #3 rst = 1'b1;
      #1;
      chk("rst_dout",  {24'h0, dout}, 32'h00);
      chk("rst_irq",   {31'h0, irq}, 32'h0);
      chk("rst_sck",   {31'h0, spi_sck}, 32'h0);
      chk("rst_mosi",  {31'h0, spi_mosi}, 32'h0);
      chk("rst_cs_n",  {31'h0, spi_cs_n}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_read(2'd3, rd); chk("rst_div",    {24'h0, rd}, 32'h03);
      bus_read(2'd1, rd); chk("rst_status", {24'h0, rd}, 32'h00);
      bus_read(2'd2, rd); chk("rst_ctrl",   {24'h0, rd}, 32'h00);
      bus_read(2'd0, rd); chk("rst_data",   {24'h0, rd}, 32'h00);

      // ---- loopback, div=0
      loop_mode = 1'b1;
      bus_write(2'd3, 8'h00);
      bus_write(2'd2, 8'h01);
      chk("lb_cs_n", {31'h0, spi_cs_n}, 32'h0);
      rbase = sck_rises; ibase = irq_cycles;
      bus_write(2'd0, 8'hA5);
      poll_busy(n);
      chk("lb_busy_cycles", n, 16);
      chk("lb_sck_pulses", sck_rises - rbase, 8);
      chk("lb_mosi_bits", {24'h0, mosi_hist[7:0]}, 32'hA5);
      bus_read(2'd1, rd); chk("lb_status_done", {24'h0, rd}, 32'h40);
      bus_read(2'd0, rd); chk("lb_data",        {24'h0, rd}, 32'hA5);
      bus_read(2'd1, rd); chk("lb_status_clr",  {24'h0, rd}, 32'h00);
      chk("lb_no_irq", irq_cycles - ibase, 0);

      // ---- slave model returns 0x3C, div=3
      loop_mode = 1'b0;
      bus_write(2'd3, 8'h03);
      slave_byte = 8'h3C;
      fall_base  = fall_cnt;
      rbase = sck_rises; ibase = irq_cycles;
      bus_write(2'd0, 8'hF0);
      poll_busy(n);
      chk("sl_busy_cycles", n, 64);
      chk("sl_sck_pulses", sck_rises - rbase, 8);
      chk("sl_mosi_bits", {24'h0, mosi_hist[7:0]}, 32'hF0);
      bus_read(2'd0, rd); chk("sl_rx", {24'h0, rd}, 32'h3C);
      chk("sl_no_irq", irq_cycles - ibase, 0);

      // ---- interrupt, div=0, irq_en only
      loop_mode = 1'b1;
      bus_write(2'd3, 8'h00);
      bus_write(2'd2, 8'h02);
      bus_write(2'd0, 8'h5A);
      cs = 1'b1; we = 1'b0; rs = 2'd1; n = 0; irq_early = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dout[7] === 1'b1) begin
            n++;
            if (irq !== 1'b0) irq_early++;
         end else break;
      end
      cs = 1'b0;
      chk("irq_busy_cycles", n, 16);
      chk("irq_low_while_busy", irq_early, 0);
      chk("irq_rise", {31'h0, irq}, 32'h1);
      bus_read(2'd0, rd);
      chk("irq_data", {24'h0, rd}, 32'h5A);
      chk("irq_hold_on_read", {31'h0, irq}, 32'h1);
      @(negedge clk);
      chk("irq_drop", {31'h0, irq}, 32'h0);

      // ---- writes ignored while busy, div=1
      bus_write(2'd2, 8'h01);
      bus_write(2'd3, 8'h01);
      rbase = sck_rises;
      bus_write(2'd0, 8'hC3);
      bus_write(2'd0, 8'h55);
      bus_write(2'd3, 8'h07);
      poll_busy(n);
      // two busy cycles were spent on the ignored writes
      chk("ign_busy_cycles", n, 30);
      chk("ign_sck_pulses", sck_rises - rbase, 8);
      chk("ign_mosi_bits", {24'h0, mosi_hist[7:0]}, 32'hC3);
      bus_read(2'd3, rd); chk("ign_div",  {24'h0, rd}, 32'h01);
      bus_read(2'd0, rd); chk("ign_data", {24'h0, rd}, 32'hC3);

      // ---- abort with reset after edge 5, div=3
      bus_write(2'd3, 8'h03);
      rbase = sck_rises;
      bus_write(2'd0, 8'hE7);
      n = 0;
      while ((sck_rises - rbase) < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_edge5", {31'h0, (n < 200)}, 32'h1);
      chk("abort_sck_high", {31'h0, spi_sck}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("abort_sck_low", {31'h0, spi_sck}, 32'h0);
      chk("abort_cs_n",    {31'h0, spi_cs_n}, 32'h1);
      chk("abort_dout",    {24'h0, dout}, 32'h00);
      @(negedge clk);
      rst = 1'b0;
      bus_read(2'd1, rd); chk("abort_status", {24'h0, rd}, 32'h00);
      bus_read(2'd0, rd); chk("abort_rx",     {24'h0, rd}, 32'h00);
      bus_read(2'd3, rd); chk("abort_div",    {24'h0, rd}, 32'h03);
      bus_write(2'd2, 8'h01);
      rbase = sck_rises;
      bus_write(2'd0, 8'h81);
      poll_busy(n);
      chk("post_busy_cycles", n, 64);
      chk("post_sck_pulses", sck_rises - rbase, 8);
      bus_read(2'd0, rd); chk("post_data", {24'h0, rd}, 32'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

CPU-bus SPI master peripheral for the 6502 system, a sibling of the ACIA on the same data bus. The top-level decoder selects it at $C000–$CFFF (CPU_AB[15:12] = 4'hc), with register select from CPU_AB[1:0]. It shifts bytes out on MOSI and in on MISO in SPI mode 0, MSB first, for external flash or SD. It raises a level IRQ on transfer completion, wire-ORed with the ACIA IRQ into CPU_IRQ.

## Interface
- DIV_RESET, 8'd3, reset value of the divider register
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- cs  in  1  chip select from the address decoder
- we  in  1  CPU write enable
- rs  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
- din  in  8  CPU write data
- dout  out  8  registered read data
- irq  out  1  interrupt request, active high
- spi_sck  out  1  serial clock; idles low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  1  slave select, active low

## Operation
- Register map:
  - DATA write: starts a transfer with din, but only when not busy; writes while busy are ignored. DATA read: last received byte.
  - STATUS (read-only): bit7 = busy, bit6 = done, bits 5:0 = 0. Writes are ignored.
  - CTRL (r/w): bit0 = ss, with spi_cs_n = ~ss; bit1 = irq_en; bits 7:2 read 0.
  - DIV (r/w): SCK half-period is DIV+1 clk cycles. Writes while busy are ignored.
- Reset values: ctrl=0, div=DIV_RESET, rx=0, shift=0, busy=0, done=0, bit/half counters=0. Outputs: dout=0, irq=0, spi_sck=0, spi_mosi=0, spi_cs_n=1.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on cs&we&rs==0. Action: shift←din, spi_mosi←din[7], half counter←0, edge counter←0.
  - In SHIFT the half counter counts 0..div. At div it wraps to 0 and an edge event occurs.
  - Edge count 1..16. Odd edges: spi_sck←1 and shift←{shift[6:0],spi_miso} (sample on rising edge). Even edges: spi_sck←0 and spi_mosi←shift[7] (next bit out on falling edge).
  - On edge 16: rx←shift, busy←0, done←1, return to IDLE. spi_mosi holds its last value.
- done is cleared by a read of DATA (cs&~we&rs==0).
- If done is set and DATA is read in the same cycle, set wins.
- A write to DATA in the same cycle that edge 16 completes is ignored (busy is still 1).
- irq = done & irq_en, registered, so it asserts one cycle after the cause.
- CTRL writes take effect immediately, including during a transfer. Deasserting ss mid-transfer does not abort the shift.
- Reset asserted mid-transfer aborts immediately. All state returns to reset values; the partially received byte is lost.
- Arithmetic: half counter is 8 bits and compares for equality with div. Edge counter is 5 bits.

## Timing
- Reads:
  - dout is registered every cycle from the current rs, independent of cs. Data is valid the cycle after the address, matching the CPU's registered read mux.
  - Read side effects (clearing done) apply only when cs is asserted.
- Writes are sampled on the posedge at which cs&we is high. busy reads 1 from the next cycle.
- Transfer length:
  - busy stays high for exactly 16×(div+1) cycles after the start cycle.
  - div=0 gives 16 cycles, with SCK = clk/2.
  - div=255 gives 4096 cycles.
- The first rising SCK edge comes div+1 cycles after busy rises. MOSI bit7 is valid from the cycle busy rises, so setup is at least one half-period.
- done and rx update in the same cycle busy falls. irq follows one cycle later.

## Test plan
- Reset:
  - Stimulus: assert rst asynchronously, mid-cycle.
  - Required: dout=0, irq=0, spi_sck=0, spi_cs_n=1. DIV reads DIV_RESET; STATUS reads 0x00.
- Loopback (MISO tied to MOSI):
  - Stimulus: div=0, CTRL=0x01, write 0xA5 to DATA.
  - Required: spi_cs_n=0; 8 SCK pulses; busy high exactly 16 cycles; STATUS=0x40; DATA reads 0xA5; a following STATUS read gives 0x00.
- Slave model:
  - Stimulus: div=3, slave returns 0x3C, write 0xF0.
  - Required: MOSI bit sequence 1,1,1,1,0,0,0,0 on SCK rises; busy high exactly 64 cycles; rx=0x3C.
- Interrupt:
  - Stimulus: CTRL=0x02 (irq_en), transfer a byte, then read DATA.
  - Required: irq rises one cycle after busy falls and drops the cycle after the DATA read. With irq_en=0, irq stays 0 throughout.
- Ignored writes:
  - Stimulus: mid-transfer, write 0x55 to DATA and 0x07 to DIV.
  - Required: the transfer completes with the original byte and timing; DIV still reads its old value.
- Abort:
  - Stimulus: assert rst after edge 5.
  - Required: SCK returns low immediately; busy=0 and done=0; a new transfer then works normally.
